ras_stack: RTL

RAS_STACK -- requirements
Module: ras_stack

---
 rtl/ras_stack.sv | 88 ++++++++
 1 files changed

// File: rtl/ras_stack.sv
// Return address stack for fetch-stage return prediction.
// Circular entry buffer with saturating occupancy and checkpoint/recover support.
module ras_stack #(
    parameter int unsigned RAS_ENTRY_NUM = 16,
    parameter int unsigned PC_WIDTH      = 32,
    parameter int unsigned PTR_WIDTH     = $clog2(RAS_ENTRY_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pushValid,
    input  logic [PC_WIDTH-1:0]  pushAddr,
    input  logic                 popValid,
    output logic [PC_WIDTH-1:0]  popAddr,
    output logic                 popAddrValid,
    output logic [PTR_WIDTH-1:0] ckptPtr,
    output logic [PTR_WIDTH:0]   ckptCount,
    output logic [PC_WIDTH-1:0]  ckptTopAddr,
    input  logic                 recoverValid,
    input  logic [PTR_WIDTH-1:0] recoverPtr,
    input  logic [PTR_WIDTH:0]   recoverCount,
    input  logic [PC_WIDTH-1:0]  recoverTopAddr
);

    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(RAS_ENTRY_NUM);

    logic [PC_WIDTH-1:0]  entry_q [RAS_ENTRY_NUM];
    logic [PTR_WIDTH-1:0] top_ptr_q, top_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic                 wr_en;
    logic [PTR_WIDTH-1:0] wr_idx;
    logic [PC_WIDTH-1:0]  wr_data;

    // Next-state selection; recovery overrides any same-cycle push/pop.
    always_comb begin
        top_ptr_d = top_ptr_q;
        count_d   = count_q;
        wr_en     = 1'b0;
        wr_idx    = top_ptr_q;
        wr_data   = pushAddr;
        if (recoverValid) begin
            top_ptr_d = recoverPtr;
            count_d   = (recoverCount > CNT_MAX) ? CNT_MAX : recoverCount;
            wr_en     = 1'b1;
            wr_idx    = recoverPtr;
            wr_data   = recoverTopAddr;
        end else if (pushValid && popValid) begin
            wr_en   = 1'b1;
            count_d = (count_q == '0) ? CNT_WIDTH'(1) : count_q;
        end else if (pushValid) begin
            // Full stack wraps onto the oldest entry while count saturates.
            top_ptr_d = top_ptr_q + PTR_WIDTH'(1);
            wr_en     = 1'b1;
            wr_idx    = top_ptr_q + PTR_WIDTH'(1);
            count_d   = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_WIDTH'(1);
        end else if (popValid && (count_q != '0)) begin
            top_ptr_d = top_ptr_q - PTR_WIDTH'(1);
            count_d   = count_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            top_ptr_q <= top_ptr_d;
            count_q   <= count_d;
        end
    end

    // Entry storage carries no reset; outputs mask it while the stack is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        popAddrValid = (count_q != '0);
        popAddr      = popAddrValid ? entry_q[top_ptr_q] : '0;
        ckptPtr      = top_ptr_q;
        ckptCount    = count_q;
        ckptTopAddr  = popAddr;
    end

endmodule
